// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32 core pipeline.
// Holds the decoded control bundle type, the major opcode constants,
// the ALU operation class encodings and the all-zero control bundle
// that a pipeline bubble uses.
package cpu_pkg;

    // Decoded control bits that travel down the pipeline together.
    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       wb_dst;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_IMM = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    // Bubble control: nothing writes memory or the register file.
    localparam ctrl_t CTRL_NOP = ctrl_t'(8'h00);

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare.
// A load sitting in EX whose destination is read by the instruction in ID
// must be separated from it by one cycle. rs2 is always compared, even for
// formats without an rs2 operand, which may cost an unnecessary stall but
// never misses a real dependency. x0 is never a dependency.
// Ports:
//   ex_mem_read_i  - load currently in EX
//   ex_rd_addr_i   - destination of the instruction in EX
//   rs1_addr_i     - ID-stage source register 1
//   rs2_addr_i     - ID-stage source register 2
//   hazard_o       - stall required this cycle
module hazard_detect (
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic [4:0] rs1_addr_i,
    input  logic [4:0] rs2_addr_i,
    output logic       hazard_o
);

    logic rd_nonzero_s;
    logic src_match_s;

    // Destination/source comparison for the load-use condition.
    always_comb begin
        rd_nonzero_s = (ex_rd_addr_i != 5'd0);
        src_match_s  = (ex_rd_addr_i == rs1_addr_i) | (ex_rd_addr_i == rs2_addr_i);
        hazard_o     = ex_mem_read_i & rd_nonzero_s & src_match_s;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage RV32 core.
// Latches decoded control, operand data, immediate, funct and register
// indices for EX. On a load-use hazard it freezes PC and IF/ID and loads a
// bubble into ID/EX, counting stall cycles in a saturating counter.
// hold_i freezes every register here while hazard outputs stay live.
// Ports:
//   clk_i, rst_i (async, active-high), hold_i (global freeze)
//   ctrl_*_i, rs*_data_i, imm_i, funct_i, rs*_addr_i, rd_addr_i - ID inputs
//   ex_*_o         - registered ID/EX contents
//   pc_write_o     - 0 holds the PC
//   if_id_write_o  - 0 holds IF/ID
//   stall_o        - load-use stall active this cycle
//   stall_cnt_o    - saturating stall-cycle count
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hold_i,
    input  logic [1:0]       ctrl_alu_op_i,
    input  logic             ctrl_alu_src_i,
    input  logic             ctrl_wb_dst_i,
    input  logic             ctrl_mem_read_i,
    input  logic             ctrl_mem_write_i,
    input  logic             ctrl_mem_to_reg_i,
    input  logic             ctrl_reg_write_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic [9:0]       funct_i,
    input  logic [4:0]       rs1_addr_i,
    input  logic [4:0]       rs2_addr_i,
    input  logic [4:0]       rd_addr_i,
    output logic [1:0]       ex_alu_op_o,
    output logic             ex_alu_src_o,
    output logic             ex_wb_dst_o,
    output logic             ex_mem_read_o,
    output logic             ex_mem_write_o,
    output logic             ex_mem_to_reg_o,
    output logic             ex_reg_write_o,
    output logic [XLEN-1:0]  ex_rs1_data_o,
    output logic [XLEN-1:0]  ex_rs2_data_o,
    output logic [XLEN-1:0]  ex_imm_o,
    output logic [9:0]       ex_funct_o,
    output logic [4:0]       ex_rs1_addr_o,
    output logic [4:0]       ex_rs2_addr_o,
    output logic [4:0]       ex_rd_addr_o,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             stall_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_t             ctrl_id_s;
    ctrl_t             ctrl_d,      ctrl_q;
    logic [XLEN-1:0]   rs1_data_d,  rs1_data_q;
    logic [XLEN-1:0]   rs2_data_d,  rs2_data_q;
    logic [XLEN-1:0]   imm_d,       imm_q;
    logic [9:0]        funct_d,     funct_q;
    logic [4:0]        rs1_addr_d,  rs1_addr_q;
    logic [4:0]        rs2_addr_d,  rs2_addr_q;
    logic [4:0]        rd_addr_d,   rd_addr_q;
    logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q;
    logic              hazard_s;

    hazard_detect u_hazard_detect (
        .ex_mem_read_i (ctrl_q.mem_read),
        .ex_rd_addr_i  (rd_addr_q),
        .rs1_addr_i    (rs1_addr_i),
        .rs2_addr_i    (rs2_addr_i),
        .hazard_o      (hazard_s)
    );

    // Pack the individual decode control inputs into one bundle.
    always_comb begin
        ctrl_id_s.alu_op     = ctrl_alu_op_i;
        ctrl_id_s.alu_src    = ctrl_alu_src_i;
        ctrl_id_s.wb_dst     = ctrl_wb_dst_i;
        ctrl_id_s.mem_read   = ctrl_mem_read_i;
        ctrl_id_s.mem_write  = ctrl_mem_write_i;
        ctrl_id_s.mem_to_reg = ctrl_mem_to_reg_i;
        ctrl_id_s.reg_write  = ctrl_reg_write_i;
    end

    // Next-state select: hold > bubble > load.
    always_comb begin
        ctrl_d      = ctrl_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        funct_d     = funct_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rd_addr_d   = rd_addr_q;
        stall_cnt_d = stall_cnt_q;
        if (hold_i) begin
            // Global freeze: every register keeps its value.
            ctrl_d = ctrl_q;
        end else if (hazard_s) begin
            // Bubble: clearing mem_read guarantees the stall ends next cycle.
            ctrl_d     = CTRL_NOP;
            rs1_data_d = {XLEN{1'b0}};
            rs2_data_d = {XLEN{1'b0}};
            imm_d      = {XLEN{1'b0}};
            funct_d    = 10'd0;
            rs1_addr_d = 5'd0;
            rs2_addr_d = 5'd0;
            rd_addr_d  = 5'd0;
            if (stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end else begin
            ctrl_d     = ctrl_id_s;
            rs1_data_d = rs1_data_i;
            rs2_data_d = rs2_data_i;
            imm_d      = imm_i;
            funct_d    = funct_i;
            rs1_addr_d = rs1_addr_i;
            rs2_addr_d = rs2_addr_i;
            rd_addr_d  = rd_addr_i;
        end
    end

    // ID/EX pipeline register and stall counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q      <= CTRL_NOP;
            rs1_data_q  <= {XLEN{1'b0}};
            rs2_data_q  <= {XLEN{1'b0}};
            imm_q       <= {XLEN{1'b0}};
            funct_q     <= 10'd0;
            rs1_addr_q  <= 5'd0;
            rs2_addr_q  <= 5'd0;
            rd_addr_q   <= 5'd0;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            ctrl_q      <= ctrl_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            funct_q     <= funct_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rd_addr_q   <= rd_addr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Output mapping of the ID/EX contents and the hazard controls.
    always_comb begin
        ex_alu_op_o     = ctrl_q.alu_op;
        ex_alu_src_o    = ctrl_q.alu_src;
        ex_wb_dst_o     = ctrl_q.wb_dst;
        ex_mem_read_o   = ctrl_q.mem_read;
        ex_mem_write_o  = ctrl_q.mem_write;
        ex_mem_to_reg_o = ctrl_q.mem_to_reg;
        ex_reg_write_o  = ctrl_q.reg_write;
        ex_rs1_data_o   = rs1_data_q;
        ex_rs2_data_o   = rs2_data_q;
        ex_imm_o        = imm_q;
        ex_funct_o      = funct_q;
        ex_rs1_addr_o   = rs1_addr_q;
        ex_rs2_addr_o   = rs2_addr_q;
        ex_rd_addr_o    = rd_addr_q;
        stall_o         = hazard_s;
        pc_write_o      = ~hazard_s & ~hold_i;
        if_id_write_o   = ~hazard_s & ~hold_i;
        stall_cnt_o     = stall_cnt_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage. A default-width instance and a
// CNT_W = 4 instance share all inputs; the narrow one exercises saturation.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        hold_i;
    logic [1:0]  ctrl_alu_op_i;
    logic        ctrl_alu_src_i, ctrl_wb_dst_i, ctrl_mem_read_i;
    logic        ctrl_mem_write_i, ctrl_mem_to_reg_i, ctrl_reg_write_i;
    logic [31:0] rs1_data_i, rs2_data_i, imm_i;
    logic [9:0]  funct_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;

    logic [1:0]  ex_alu_op_o;
    logic        ex_alu_src_o, ex_wb_dst_o, ex_mem_read_o, ex_mem_write_o;
    logic        ex_mem_to_reg_o, ex_reg_write_o;
    logic [31:0] ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
    logic [9:0]  ex_funct_o;
    logic [4:0]  ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o;
    logic        pc_write_o, if_id_write_o, stall_o;
    logic [31:0] stall_cnt_o;

    logic [1:0]  n_alu_op;
    logic        n_alu_src, n_wb_dst, n_mem_read, n_mem_write, n_mem_to_reg, n_reg_write;
    logic [31:0] n_rs1_data, n_rs2_data, n_imm;
    logic [9:0]  n_funct;
    logic [4:0]  n_rs1_addr, n_rs2_addr, n_rd_addr;
    logic        n_pc_write, n_if_id_write, n_stall;
    logic [3:0]  n_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    id_ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i),
        .ctrl_alu_op_i(ctrl_alu_op_i), .ctrl_alu_src_i(ctrl_alu_src_i),
        .ctrl_wb_dst_i(ctrl_wb_dst_i), .ctrl_mem_read_i(ctrl_mem_read_i),
        .ctrl_mem_write_i(ctrl_mem_write_i), .ctrl_mem_to_reg_i(ctrl_mem_to_reg_i),
        .ctrl_reg_write_i(ctrl_reg_write_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .funct_i(funct_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rd_addr_i(rd_addr_i),
        .ex_alu_op_o(ex_alu_op_o), .ex_alu_src_o(ex_alu_src_o),
        .ex_wb_dst_o(ex_wb_dst_o), .ex_mem_read_o(ex_mem_read_o),
        .ex_mem_write_o(ex_mem_write_o), .ex_mem_to_reg_o(ex_mem_to_reg_o),
        .ex_reg_write_o(ex_reg_write_o),
        .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_imm_o(ex_imm_o), .ex_funct_o(ex_funct_o),
        .ex_rs1_addr_o(ex_rs1_addr_o), .ex_rs2_addr_o(ex_rs2_addr_o),
        .ex_rd_addr_o(ex_rd_addr_o),
        .pc_write_o(pc_write_o), .if_id_write_o(if_id_write_o),
        .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
    );

    id_ex_stage #(.XLEN(32), .CNT_W(4)) dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i),
        .ctrl_alu_op_i(ctrl_alu_op_i), .ctrl_alu_src_i(ctrl_alu_src_i),
        .ctrl_wb_dst_i(ctrl_wb_dst_i), .ctrl_mem_read_i(ctrl_mem_read_i),
        .ctrl_mem_write_i(ctrl_mem_write_i), .ctrl_mem_to_reg_i(ctrl_mem_to_reg_i),
        .ctrl_reg_write_i(ctrl_reg_write_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .funct_i(funct_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rd_addr_i(rd_addr_i),
        .ex_alu_op_o(n_alu_op), .ex_alu_src_o(n_alu_src),
        .ex_wb_dst_o(n_wb_dst), .ex_mem_read_o(n_mem_read),
        .ex_mem_write_o(n_mem_write), .ex_mem_to_reg_o(n_mem_to_reg),
        .ex_reg_write_o(n_reg_write),
        .ex_rs1_data_o(n_rs1_data), .ex_rs2_data_o(n_rs2_data),
        .ex_imm_o(n_imm), .ex_funct_o(n_funct),
        .ex_rs1_addr_o(n_rs1_addr), .ex_rs2_addr_o(n_rs2_addr),
        .ex_rd_addr_o(n_rd_addr),
        .pc_write_o(n_pc_write), .if_id_write_o(n_if_id_write),
        .stall_o(n_stall), .stall_cnt_o(n_stall_cnt)
    );

    // All registered ID/EX contents of the default instance, 129 bits.
    wire [128:0] ex_all = {ex_alu_op_o, ex_alu_src_o, ex_wb_dst_o, ex_mem_read_o,
                           ex_mem_write_o, ex_mem_to_reg_o, ex_reg_write_o,
                           ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_funct_o,
                           ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o};
    wire [128:0] n_all  = {n_alu_op, n_alu_src, n_wb_dst, n_mem_read, n_mem_write,
                           n_mem_to_reg, n_reg_write, n_rs1_data, n_rs2_data, n_imm,
                           n_funct, n_rs1_addr, n_rs2_addr, n_rd_addr};

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] aop, input logic asrc, input logic mrd,
                         input logic m2r, input logic rw, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] im);
        ctrl_alu_op_i     = aop;
        ctrl_alu_src_i    = asrc;
        ctrl_wb_dst_i     = 1'b0;
        ctrl_mem_read_i   = mrd;
        ctrl_mem_write_i  = 1'b0;
        ctrl_mem_to_reg_i = m2r;
        ctrl_reg_write_i  = rw;
        rs1_addr_i        = rs1;
        rs2_addr_i        = rs2;
        rd_addr_i         = rd;
        rs1_data_i        = d1;
        rs2_data_i        = 32'h0000_1234;
        imm_i             = im;
        funct_i           = 10'h000;
        #1;
    endtask

    task automatic lw(input logic [4:0] rd, input logic [31:0] d1);
        drive(2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 5'd0, rd, d1, 32'd8);
    endtask

    task automatic add_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        drive(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, rs1, rs2, rd, 32'h0000_0055, 32'd0);
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset with every ID input driven to ones.
        rst_i = 1'b1; hold_i = 1'b0;
        ctrl_alu_op_i = 2'b11; ctrl_alu_src_i = 1'b1; ctrl_wb_dst_i = 1'b1;
        ctrl_mem_read_i = 1'b1; ctrl_mem_write_i = 1'b1; ctrl_mem_to_reg_i = 1'b1;
        ctrl_reg_write_i = 1'b1;
        rs1_data_i = 32'hFFFF_FFFF; rs2_data_i = 32'hFFFF_FFFF; imm_i = 32'hFFFF_FFFF;
        funct_i = 10'h3FF; rs1_addr_i = 5'h1F; rs2_addr_i = 5'h1F; rd_addr_i = 5'h1F;
        #2;
        check_eq("rst_ex_all", ex_all, 129'd0);
        check_eq("rst_stall", stall_o, 1'b0);
        check_eq("rst_pc_write", pc_write_o, 1'b1);
        check_eq("rst_if_id_write", if_id_write_o, 1'b1);
        check_eq("rst_cnt", stall_cnt_o, 32'd0);
        step; step;
        rst_i = 1'b0;
        step;

        // lw x5 ; add x6,x5,x7 -> one stall cycle, bubble, then add.
        lw(5'd5, 32'hCAFE_0001);
        step;
        check_eq("lw_latched_rd", ex_rd_addr_o, 5'd5);
        add_r(5'd6, 5'd5, 5'd7);
        check_eq("lu_stall", stall_o, 1'b1);
        check_eq("lu_pc_write", pc_write_o, 1'b0);
        check_eq("lu_if_id_write", if_id_write_o, 1'b0);
        step;
        check_eq("lu_bubble_all", ex_all, 129'd0);
        check_eq("lu_bubble_stall", stall_o, 1'b0);
        check_eq("lu_bubble_pc_write", pc_write_o, 1'b1);
        check_eq("lu_cnt", stall_cnt_o, 32'd1);
        step;
        check_eq("lu_add_rs1", ex_rs1_addr_o, 5'd5);
        check_eq("lu_add_rd", ex_rd_addr_o, 5'd6);
        check_eq("lu_add_rw", ex_reg_write_o, 1'b1);
        check_eq("lu_add_aluop", ex_alu_op_o, 2'b10);
        check_eq("lu_add_data", ex_rs1_data_o, 32'h0000_0055);

        // lw x0 ; add x6,x0,x0 -> no stall.
        lw(5'd0, 32'h1111_1111);
        step;
        add_r(5'd6, 5'd0, 5'd0);
        check_eq("x0_stall", stall_o, 1'b0);
        check_eq("x0_pc_write", pc_write_o, 1'b1);
        step;
        check_eq("x0_add_rd", ex_rd_addr_o, 5'd6);
        check_eq("x0_cnt", stall_cnt_o, 32'd1);

        // lw x5 ; addi x6,x1,5 (rs2 field = 5) -> conservative stall.
        lw(5'd5, 32'h2222_2222);
        step;
        drive(2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 5'd5, 5'd6, 32'h0000_0077, 32'd5);
        check_eq("cons_stall", stall_o, 1'b1);
        step;
        check_eq("cons_bubble_rw", ex_reg_write_o, 1'b0);
        check_eq("cons_cnt", stall_cnt_o, 32'd2);
        step;
        check_eq("cons_addi_imm", ex_imm_o, 32'd5);
        check_eq("cons_addi_aluop", ex_alu_op_o, 2'b01);

        // lw x5 ; add x6,x1,x2 -> independent, no stall.
        lw(5'd5, 32'h3333_3333);
        step;
        add_r(5'd6, 5'd1, 5'd2);
        check_eq("indep_stall", stall_o, 1'b0);
        step;
        check_eq("indep_add_rd", ex_rd_addr_o, 5'd6);
        check_eq("indep_cnt", stall_cnt_o, 32'd2);

        // Hazard under hold for 3 cycles, then release.
        lw(5'd5, 32'hAAAA_5555);
        step;
        add_r(5'd6, 5'd5, 5'd7);
        hold_i = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("hold_stall", stall_o, 1'b1);
            check_eq("hold_pc_write", pc_write_o, 1'b0);
            step;
            check_eq("hold_mem_read", ex_mem_read_o, 1'b1);
            check_eq("hold_rs1_data", ex_rs1_data_o, 32'hAAAA_5555);
            check_eq("hold_rd", ex_rd_addr_o, 5'd5);
            check_eq("hold_cnt", stall_cnt_o, 32'd2);
        end
        hold_i = 1'b0;
        #1;
        check_eq("rel_pc_write", pc_write_o, 1'b0);
        step;
        check_eq("rel_bubble_all", ex_all, 129'd0);
        check_eq("rel_cnt", stall_cnt_o, 32'd3);
        step;
        check_eq("rel_add_rd", ex_rd_addr_o, 5'd6);

        // Reset asserted in the middle of a stall.
        lw(5'd5, 32'h4444_4444);
        step;
        add_r(5'd6, 5'd5, 5'd7);
        check_eq("mid_pre_stall", stall_o, 1'b1);
        rst_i = 1'b1;
        #1;
        check_eq("mid_ex_all", ex_all, 129'd0);
        check_eq("mid_stall", stall_o, 1'b0);
        check_eq("mid_pc_write", pc_write_o, 1'b1);
        check_eq("mid_cnt", stall_cnt_o, 32'd0);
        check_eq("mid_cnt4", n_stall_cnt, 4'd0);
        #1;
        rst_i = 1'b0;
        step;
        check_eq("post_rst_add_rd", ex_rd_addr_o, 5'd6);
        check_eq("post_rst_cnt", stall_cnt_o, 32'd0);

        // Saturation on the 4-bit counter: 17 back-to-back dependent loads.
        for (int i = 1; i <= 17; i++) begin
            lw(5'd5, 32'h5555_0000);
            step;
            add_r(5'd6, 5'd5, 5'd7);
            check_eq("sat_stall4", n_stall, 1'b1);
            step;
            if (i == 14) check_eq("sat_cnt4_14", n_stall_cnt, 4'hE);
            if (i >= 15) check_eq("sat_cnt4_hold", n_stall_cnt, 4'hF);
            check_eq("sat_bubble4", n_all, 129'd0);
        end
        check_eq("sat_cnt32", stall_cnt_o, 32'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 5-stage RV32 core; sits directly downstream of the decode control unit and register file.
- Latches decoded control bits, operand data, immediate, funct and register addresses for EX.
- Contains load-use hazard detection: stalls PC and IF/ID, and injects a bubble into ID/EX.
- Counts stall cycles for performance monitoring.

Parameters:
- XLEN, 32, datapath width
- CNT_W, 32, stall counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous and active-high
- hold_i  in  1  global freeze (e.g. memory wait); all state held
- ctrl_alu_op_i  in  2  from decode control
- ctrl_alu_src_i, ctrl_wb_dst_i, ctrl_mem_read_i, ctrl_mem_write_i, ctrl_mem_to_reg_i, ctrl_reg_write_i  in  1 each  from decode control
- rs1_data_i, rs2_data_i  in  XLEN  register file read data
- imm_i  in  XLEN  sign-extended immediate
- funct_i  in  10  {funct7, funct3}
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  5  ID-stage register indices
- ex_* outputs (alu_op 2, alu_src, wb_dst, mem_read, mem_write, mem_to_reg, reg_write, rs1_data, rs2_data, imm, funct, rs1_addr, rs2_addr, rd_addr)  out  same widths  registered ID/EX contents
- pc_write_o  out  1  0 = hold PC
- if_id_write_o  out  1  0 = hold IF/ID
- stall_o  out  1  load-use stall active this cycle
- stall_cnt_o  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (async, rst_i=1): every ex_* output = 0, stall_cnt_o = 0. stall_o = 0 and pc_write_o/if_id_write_o = 1 follow from the cleared state. Reset mid-stall aborts the stall; the first post-reset cycle has no hazard.
- Hazard detect (combinational, zero latency):
  - hazard = ex_mem_read_o & (ex_rd_addr_o != 0) & (ex_rd_addr_o == rs1_addr_i | ex_rd_addr_o == rs2_addr_i).
  - Conservative: rs2 is compared even for I-type and load instructions.
- Outputs: stall_o = hazard; pc_write_o = if_id_write_o = ~hazard & ~hold_i.
- Register update on posedge, priority rst_i > hold_i > hazard > load:
  - hold_i=1: all ex_* and the counter keep their values. stall_o is still evaluated.
  - hazard & ~hold_i: bubble. All ex_* control bits = 0; data, imm, funct and address fields = 0. stall_cnt_o += 1, saturating at all-ones with no wrap.
  - otherwise: ex_* <= ID inputs.
- A bubble has mem_read = 0, so a stall lasts exactly one cycle. The next cycle reloads the held ID instruction.
- Branch flush is handled at IF/ID. The taken branch itself passes through with reg_write = 0 from decode, and this stage treats it as normal.
- rd = x0 never triggers a stall.
- Back-to-back loads each produce an independent one-cycle stall when dependent.

Decomposition:
- Shared package cpu_pkg:
  - typedef ctrl_t (packed struct: alu_op[1:0], alu_src, wb_dst, mem_read, mem_write, mem_to_reg, reg_write)
  - opcode constants OP_RTYPE=7'b0110011, OP_ITYPE=7'b0010011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_BRANCH=7'b1100011
  - ALUOP_MEM=2'b00, ALUOP_IMM=2'b01, ALUOP_R=2'b10
  - CTRL_NOP = all zeros
- Sub-module hazard_detect: combinational load-use compare that produces hazard. Reusable by later forwarding work.

Test Plan:
- Reset with all ID inputs = 1 → all ex_* = 0, stall_o = 0, pc_write_o = 1, stall_cnt_o = 0. Assert rst_i mid-stall → same values immediately, before any clock.
- lw x5 then add x6,x5,x7 → exactly one cycle with stall_o = 1 and pc_write_o = 0, a bubble (ex_reg_write = 0, ex_mem_read = 0), then add latched with rs1_addr = 5. stall_cnt_o = 1.
- lw x0 then add x6,x0,x0 → no stall; add latched the next cycle.
- lw x5 then addi x6,x1,imm whose rs2 field decodes as 5 → stall asserted (conservative). lw x5 then add x6,x1,x2 → no stall.
- Hazard present with hold_i = 1 for 3 cycles → ex_* unchanged, stall_cnt_o unchanged, pc_write_o = 0. hold_i released → bubble inserted, count +1.
- Preload stall_cnt_o to all-ones via repeated stalls (CNT_W = 4 override), then 2 more stalls → stays 4'hF.
